// File: rtl/fwd_pass_sequencer.sv
// rtl/fwd_pass_sequencer.sv - batch forward-pass sequencer for the output neuron
//
// Walks the output neuron through NUM_SAMPLES forward passes per batch:
// FETCH (sample handshake) -> COMPUTE (weighted sum) -> LOSS -> ACC (sum loss).
// The per-sample loss is added into a saturating 48-bit batch sum.
//
// Optional feature macro: FWD_SEQ_TIMEOUT_EN
//   defined   : FETCH gives up after TIMEOUT_CYC idle cycles and ends the batch
//               early, raising sticky timeout_o.
//   undefined : FETCH waits indefinitely, timeout_o stays 0.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), async active-low reset
//   start_i                  batch start pulse, honoured in IDLE only
//   sample_valid_i/_ready_o  sample source handshake (ready only in FETCH)
//   sample_tgt_i             target label offered with the sample
//   final_i, loss_i          registered weighted sum / loss from the neuron
//   neuron_en_o, f0_pass_o   neuron enable and loss-pass select
//   target_o                 latched target, drives neuron init_i
//   sample_idx_o             current sample index
//   loss_sum_o, skip_cnt_o   batch loss sum, count of final_i==0 samples
//   busy_o, done_o           not-IDLE flag, one-cycle batch-end pulse
//   timeout_o                sticky FETCH timeout flag
module fwd_pass_sequencer #(
  parameter int NUM_SAMPLES = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        sample_valid_i,
  input  logic [3:0]  sample_tgt_i,
  output logic        sample_ready_o,
  input  logic [22:0] final_i,
  input  logic [45:0] loss_i,
  output logic        neuron_en_o,
  output logic        f0_pass_o,
  output logic [3:0]  target_o,
  output logic [7:0]  sample_idx_o,
  output logic [47:0] loss_sum_o,
  output logic [7:0]  skip_cnt_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_COMPUTE, S_LOSS, S_ACC, S_DONE
  } state_e;

  localparam logic [7:0]  LAST_IDX = 8'(NUM_SAMPLES - 1);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  tgt_q, tgt_d;
  logic [47:0] sum_q, sum_d;
  logic [7:0]  skip_q, skip_d;
  logic        timeout_q, timeout_d;
  logic        handshake;
  logic [48:0] sum_ext;

  assign handshake = (state_q == S_FETCH) && sample_valid_i;
  // One extra bit catches the carry that signals saturation.
  assign sum_ext   = {1'b0, sum_q} + {3'b000, loss_i};

`ifdef FWD_SEQ_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic        wait_expired;

  // Zero outside FETCH, so every FETCH entry starts counting from 0.
  assign wait_d       = (state_q == S_FETCH) ? wait_q + 16'd1 : 16'd0;
  assign wait_expired = (wait_q == TO_LIMIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) wait_q <= 16'd0;
    else        wait_q <= wait_d;
  end
`else
  logic        wait_expired;
  logic        unused_timeout_cfg;

  assign wait_expired       = 1'b0;
  assign unused_timeout_cfg = ^TO_LIMIT;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tgt_d     = tgt_q;
    sum_d     = sum_q;
    skip_d    = skip_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_FETCH;
          idx_d     = 8'd0;
          sum_d     = 48'd0;
          skip_d    = 8'd0;
          timeout_d = 1'b0;
        end
      end
      S_FETCH: begin
        // A handshake takes priority over an expiring wait count.
        if (handshake) begin
          tgt_d   = sample_tgt_i;
          state_d = S_COMPUTE;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_COMPUTE: state_d = S_LOSS;
      S_LOSS:    state_d = S_ACC;
      S_ACC: begin
        // With final_i==0 the neuron left loss_i untouched, so it is stale.
        if (final_i != 23'd0) begin
          sum_d = sum_ext[48] ? {48{1'b1}} : sum_ext[47:0];
        end else if (skip_q != 8'hFF) begin
          skip_d = skip_q + 8'd1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'd0;
      tgt_q     <= 4'd0;
      sum_q     <= 48'd0;
      skip_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tgt_q     <= tgt_d;
      sum_q     <= sum_d;
      skip_q    <= skip_d;
      timeout_q <= timeout_d;
    end
  end

  // Pure decodes of the state register: no input-to-output paths.
  assign sample_ready_o = (state_q == S_FETCH);
  assign neuron_en_o    = (state_q == S_COMPUTE) || (state_q == S_LOSS);
  assign f0_pass_o      = (state_q == S_LOSS);
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign target_o       = tgt_q;
  assign sample_idx_o   = idx_q;
  assign loss_sum_o     = sum_q;
  assign skip_cnt_o     = skip_q;
  assign timeout_o      = timeout_q;

endmodule
